array_slicing: RTL and testbench
================================

Name: array_slicing

Overview:
- Registered bit-field slicer: splits a DATA_W-bit input word into a B_W-bit upper field (b) and a C_W-bit lower field (c).
- A 2-bit mode selects one of four split arrangements.
- Used as a data-manipulation stage between a word source and field consumers.
- One clock; one-cycle latency; valid-qualified.

Parameters:
- DATA_W, 8, input word width (must be even, ≥ 2).
- B_W, 5, width of field b (1 ≤ B_W < DATA_W).
- C_W, DATA_W-B_W (derived, not overridable), width of field c.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a and mode this cycle.
- a  input  DATA_W  input word.
- mode  input  2  split arrangement, sampled with in_valid.
- b  output  B_W  registered upper/first field.
- c  output  C_W  registered lower/second field.
- out_valid  output  1  high for one cycle when b/c carry a new result.

Behaviour:
- Reset (rst=1 at a rising edge): b=0, c=0, out_valid=0. Reset has priority over in_valid.
- Latency: a word accepted at edge N appears on b/c at edge N (registered); out_valid is high in the following cycle.
- No back-pressure; a new word may be accepted every cycle.
- in_valid=0: b and c hold their previous values; out_valid=0 next cycle.
- Mode semantics (bit indices for defaults DATA_W=8, B_W=5; generalise by width):
  - mode 00 straight: b=a[DATA_W-1:C_W] (a[7:3]), c=a[C_W-1:0] (a[2:0]).
  - mode 01 low-first: b=a[B_W-1:0] (a[4:0]), c=a[DATA_W-1:B_W] (a[7:5]).
  - mode 10 bit-reversed: form r with r[i]=a[DATA_W-1-i], then apply the straight split to r.
  - mode 11 half-swap: form s={a[DATA_W/2-1:0], a[DATA_W-1:DATA_W/2]}, then apply the straight split to s.
- Every input bit lands in exactly one output bit; no bit is dropped or duplicated in any mode.
- Purely combinational selection feeding one output register stage; no arithmetic.
- Reset asserted mid-stream clears outputs on that edge; the word presented on that edge is discarded.
- First accepted word after reset deassertion is processed normally.
- X on mode while in_valid=0 has no effect.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=8'hFF -> b=00000, c=000, out_valid=0.
- Mode 00 back-to-back, one word per cycle:
  - a=11010001 -> b=11010, c=001.
  - a=00110101 -> b=00110, c=101.
  - a=10001100 -> b=10001, c=100.
  - out_valid high for 3 consecutive cycles, each one cycle after its word.
- Modes 01/10/11 with a=11010001:
  - mode 01 -> b=10001, c=110.
  - mode 10 -> b=10001, c=011.
  - mode 11 -> b=00011, c=101.
- Hold: after a=11010001 in mode 00, drive in_valid=0 with a=00000000 for 3 cycles -> b stays 11010, c stays 001, out_valid=0.
- Mid-stream reset: stream mode 00 words, assert rst on the edge with a=10001100 -> b=00000, c=000, out_valid=0. Next valid word a=00110101 -> b=00110, c=101.
- Random: 1000 random (a, mode, in_valid) triples checked against a reference model of the four mode equations, including out_valid timing.

Source files
------------

// File: rtl/array_slicing.sv
// rtl/array_slicing.sv - registered bit-field slicer with four split arrangements
//
// Splits a DATA_W-bit word into an upper field b (B_W bits) and a lower
// field c (C_W = DATA_W - B_W bits). The split arrangement is chosen by mode:
//   00 straight     : {b, c} = a
//   01 low-first    : {c, b} = a
//   10 bit-reversed : {b, c} = a with bit order reversed
//   11 half-swap    : {b, c} = {a low half, a high half}
// Every arrangement is a pure permutation of the input bits.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset, priority over in_valid
//   in_valid  in   qualifies a and mode
//   a         in   DATA_W input word
//   mode      in   2-bit split arrangement
//   b         out  B_W registered first field
//   c         out  C_W registered second field
//   out_valid out  high for one cycle after each accepted word

module array_slicing #(
    parameter int  DATA_W = 8,
    parameter int  B_W    = 5,
    localparam int C_W    = DATA_W - B_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [1:0]        mode,
    output logic [B_W-1:0]    b,
    output logic [C_W-1:0]    c,
    output logic              out_valid
);

    logic [DATA_W-1:0] rev_a;
    logic [DATA_W-1:0] swap_a;
    logic [B_W-1:0]    b_d, b_q;
    logic [C_W-1:0]    c_d, c_q;
    logic              valid_q;

    always_comb begin
        rev_a = '0;
        for (int i = 0; i < DATA_W; i++) begin
            rev_a[i] = a[DATA_W-1-i];
        end
        swap_a = {a[DATA_W/2-1:0], a[DATA_W-1:DATA_W/2]};
    end

    // Next field values; only consumed when in_valid is high, so an unknown
    // mode while idle never reaches the registers.
    always_comb begin
        b_d = '0;
        c_d = '0;
        case (mode)
            2'b00:   {b_d, c_d} = a;
            2'b01:   {c_d, b_d} = a;
            2'b10:   {b_d, c_d} = rev_a;
            2'b11:   {b_d, c_d} = swap_a;
            default: {b_d, c_d} = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                b_q <= b_d;
                c_q <= c_d;
            end
        end
    end

    assign b         = b_q;
    assign c         = c_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_array_slicing.sv
// tb/tb_array_slicing.sv - self-checking bench for array_slicing

module tb_array_slicing;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] a;
    logic [1:0] mode;
    logic [4:0] b;
    logic [2:0] c;
    logic       out_valid;

    int total;
    int bad;

    array_slicing dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .mode      (mode),
        .b         (b),
        .c         (c),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference split, returned as {b, c}.
    function automatic logic [7:0] ref_split(input logic [7:0] w, input logic [1:0] m);
        logic [7:0] r;
        case (m)
            2'd0: r = w;
            2'd1: r = {w[4:0], w[7:5]};
            2'd2: for (int k = 0; k < 8; k++) r[7-k] = w[k];
            default: r = {w[3:0], w[7:4]};
        endcase
        return r;
    endfunction

    // Inputs are changed 1 time unit after a rising edge; outputs are
    // sampled at the same point, after the edge has settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 8'hFF; mode = 2'b00;
        for (int n = 0; n < 2; n++) begin
            tick();
            total++;
            if ({b, c, out_valid} !== 9'b00000_000_0) begin
                bad++;
                $display("FAIL reset[%0d]: got b=%b c=%b ov=%b want b=00000 c=000 ov=0", n, b, c, out_valid);
            end
        end
        rst = 1'b0; in_valid = 1'b0; a = 8'h00;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [8:0] exp  [3];
        words = '{8'b11010001, 8'b00110101, 8'b10001100};
        exp   = '{9'b11010_001_1, 9'b00110_101_1, 9'b10001_100_1};
        mode = 2'b00;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; a = words[n];
            tick();
            total++;
            if ({b, c, out_valid} !== exp[n]) begin
                bad++;
                $display("FAIL b2b[%0d]: got %b_%b_%b want %b", n, b, c, out_valid, exp[n]);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_modes();
        logic [1:0] modes [3];
        logic [7:0] exp   [3];
        modes = '{2'b01, 2'b10, 2'b11};
        exp   = '{8'b10001_110, 8'b10001_011, 8'b00011_101};
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; a = 8'b11010001; mode = modes[n];
            tick();
            total++;
            if ({b, c, out_valid} !== {exp[n], 1'b1}) begin
                bad++;
                $display("FAIL mode%b: got b=%b c=%b ov=%b want %b ov=1", modes[n], b, c, out_valid, exp[n]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_hold();
        in_valid = 1'b1; a = 8'b11010001; mode = 2'b00;
        tick();
        total++;
        if ({b, c, out_valid} !== 9'b11010_001_1) begin
            bad++;
            $display("FAIL hold_load: got %b_%b_%b want 11010_001_1", b, c, out_valid);
        end
        in_valid = 1'b0; a = 8'h00; mode = 2'bxx;
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if ({b, c, out_valid} !== 9'b11010_001_0) begin
                bad++;
                $display("FAIL hold[%0d]: got %b_%b_%b want 11010_001_0", n, b, c, out_valid);
            end
        end
        mode = 2'b00;
    endtask

    task automatic test_midstream_reset();
        in_valid = 1'b1; mode = 2'b00; a = 8'b11010001;
        tick();
        a = 8'b00110101;
        tick();
        total++;
        if ({b, c, out_valid} !== 9'b00110_101_1) begin
            bad++;
            $display("FAIL mid_pre: got %b_%b_%b want 00110_101_1", b, c, out_valid);
        end
        rst = 1'b1; a = 8'b10001100;
        tick();
        total++;
        if ({b, c, out_valid} !== 9'b00000_000_0) begin
            bad++;
            $display("FAIL mid_rst: got %b_%b_%b want 00000_000_0", b, c, out_valid);
        end
        rst = 1'b0; a = 8'b00110101;
        tick();
        total++;
        if ({b, c, out_valid} !== 9'b00110_101_1) begin
            bad++;
            $display("FAIL mid_post: got %b_%b_%b want 00110_101_1", b, c, out_valid);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_bc;
        logic       exp_ov;
        exp_bc = {b, c};
        if (out_valid !== 1'b0 || exp_bc !== 8'b00110_101) begin
            exp_bc = 8'b00110_101;
        end
        for (int n = 0; n < 1000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            a        = 8'($urandom);
            mode     = 2'($urandom);
            if (in_valid) exp_bc = ref_split(a, mode);
            exp_ov = in_valid;
            tick();
            total++;
            if ({b, c, out_valid} !== {exp_bc, exp_ov}) begin
                bad++;
                $display("FAIL rand[%0d] a=%b mode=%b iv=%b: got %b_%b_%b want %b_%b", n, a, mode, in_valid, b, c, out_valid, exp_bc, exp_ov);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; in_valid = 1'b0; a = 8'h00; mode = 2'b00;
        #1;
        test_reset();
        test_back_to_back();
        test_modes();
        test_hold();
        test_midstream_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
